parity_frame_checker: RTL
=========================

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter ODD_PARITY, default 0, meaning: 0 = even parity across 4 data bits plus parity bit, 1 = odd parity.
REQ-002 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_bit  input  1  serial frame bit; data MSB first (inA position first), then parity bit.
REQ-005 in_valid  input  1  in_bit is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_bit this cycle.
REQ-007 out_data  output  4  received data word; bit3 = first bit received.
REQ-008 out_err  output  1  parity mismatch flag for the presented frame.
REQ-009 out_valid  output  1  out_data and out_err are valid.
REQ-010 out_ready  input  1  consumer accepts the presented frame.
REQ-011 clr_cnt  input  1  synchronous clear of both counters.
REQ-012 frame_cnt  output  8  frames completed, wrapping.
REQ-013 err_cnt  output  8  frames with parity error, saturating.

Function
REQ-014 A bit is accepted only in a cycle where in_valid=1 and in_ready=1; at all other times in_bit is ignored.
REQ-015 FSM states: S_DATA, S_PAR, S_OUT.
REQ-016 S_DATA: in_ready=1.
  - Each accepted bit shifts into the data register and increments the 2-bit bit_cnt.
  - When the accepted bit has bit_cnt==3, the next state is S_PAR.
REQ-017 S_PAR: in_ready=1.
  - On an accepted bit, compute err = (XOR of 4 data bits) XOR parity_bit XOR ODD_PARITY.
  - Register err, then go to S_OUT.
REQ-018 S_OUT: in_ready=0 and out_valid=1.
  - out_data and out_err stay stable until out_ready=1.
  - On out_ready=1, the next state is S_DATA and bit_cnt=0.
REQ-019 Latency: out_valid rises in the cycle after the parity bit is accepted. Minimum frame period is 6 cycles when in_valid and out_ready are held at 1.
REQ-020 Counter updates:
  - frame_cnt increments by 1 on the S_PAR to S_OUT transition and wraps 255 to 0.
  - err_cnt increments on the same transition when err=1 and holds at 255.
REQ-021 clr_cnt=1 sets both counters to 0 in the next cycle. It takes priority over a simultaneous increment and does not affect the FSM or the data path.
REQ-022 out_data and out_err hold their last presented values outside S_OUT. Consumers use them only while out_valid=1.
REQ-023 Back-pressure: while out_ready=0 in S_OUT, no input is consumed and no input bit is lost. The sender sees in_ready=0.

Reset
REQ-024 rst=1 at a clock edge sets the following, regardless of state and including mid-frame:
  - state=S_DATA, bit_cnt=0, data register=0;
  - out_data=0, out_err=0, out_valid=0;
  - frame_cnt=0, err_cnt=0;
  - in_ready=1 from the first cycle after reset.
REQ-025 A partial frame interrupted by reset is discarded and not counted.

Structure
REQ-026 Shared package parity_pkg holds:
  - the state enumeration (S_DATA, S_PAR, S_OUT);
  - DATA_W=4;
  - CNT_W=8;
  - the ERR_SAT constant 8'hFF.
REQ-027 One sub-module: the existing parity_bit (ports inA..inD, outE), fed from the data register bits 3..0. Its outE is the expected even parity.

Verification
REQ-028 Frame 1,0,1,1 + parity 1, ODD_PARITY=0, out_ready=1 -> out_valid for 1 cycle, out_data=4'b1011, out_err=0, frame_cnt=1, err_cnt=0.
REQ-029 Frame 1,0,1,1 + parity 0 -> out_err=1, err_cnt=1. Repeat the error frame 300 times -> err_cnt=255 and frame_cnt=44 (300 mod 256).
REQ-030 out_ready=0 for 10 cycles after out_valid, with in_valid=1 throughout:
  - out_valid and out_data stay stable;
  - in_ready=0;
  - the next frame decodes correctly after out_ready=1.
REQ-031 Assert rst after 2 data bits of a frame -> all outputs 0. A following full frame 0,1,1,0 + parity 0 -> out_data=4'b0110, out_err=0, frame_cnt=1.
REQ-032 clr_cnt=1 in the same cycle as an error-frame completion -> frame_cnt=0 and err_cnt=0 next cycle. out_valid still asserts with out_err=1.
REQ-033 Exhaustive sweep of all 16 data words with correct and incorrect parity, ODD_PARITY=0 and 1, with gaps in in_valid -> out_err matches the reference XOR in every case.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity frame checker.
// Frame = DATA_W data bits (MSB first) followed by one parity bit.
package parity_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0] ERR_SAT = 8'hFF;

    typedef enum logic [1:0] {
        S_DATA,
        S_PAR,
        S_OUT
    } frameStateT;

endpackage

// File: rtl/parity_bit.sv
// Even-parity generator over four bits: outE makes the five-bit group even.
module parity_bit (
    input  logic inA,
    input  logic inB,
    input  logic inC,
    input  logic inD,
    output logic outE
);

    assign outE = inA ^ inB ^ inC ^ inD;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: collects 4 data bits plus parity, presents the word
// with a parity-error flag under valid/ready, and keeps frame/error counters.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    frameStateT        stateQ, stateD;
    logic [1:0]        bitCntQ, bitCntD;
    logic [DATA_W-1:0] dataQ, dataD;
    logic [DATA_W-1:0] outDataQ, outDataD;
    logic              outErrQ, outErrD;
    logic [CNT_W-1:0]  frameCntQ, frameCntD;
    logic [CNT_W-1:0]  errCntQ, errCntD;
    logic              expParity;
    logic              frameDone;
    logic              frameErr;

    parity_bit uParityBit (
        .inA  (dataQ[3]),
        .inB  (dataQ[2]),
        .inC  (dataQ[1]),
        .inD  (dataQ[0]),
        .outE (expParity)
    );

    always_comb begin
        stateD    = stateQ;
        bitCntD   = bitCntQ;
        dataD     = dataQ;
        outDataD  = outDataQ;
        outErrD   = outErrQ;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        frameDone = 1'b0;
        frameErr  = 1'b0;

        unique case (stateQ)
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dataD   = {dataQ[DATA_W-2:0], in_bit};
                    bitCntD = bitCntQ + 2'd1;
                    if (bitCntQ == 2'd3) begin
                        stateD = S_PAR;
                    end
                end
            end
            S_PAR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    frameErr  = expParity ^ in_bit ^ ODD_PARITY;
                    outDataD  = dataQ;
                    outErrD   = frameErr;
                    frameDone = 1'b1;
                    stateD    = S_OUT;
                end
            end
            S_OUT: begin
                // Holding in_ready low here is what gives lossless back-pressure.
                out_valid = 1'b1;
                if (out_ready) begin
                    stateD  = S_DATA;
                    bitCntD = 2'd0;
                end
            end
            default: begin
                stateD  = S_DATA;
                bitCntD = 2'd0;
            end
        endcase
    end

    always_comb begin
        frameCntD = frameCntQ;
        errCntD   = errCntQ;
        if (clr_cnt) begin
            frameCntD = '0;
            errCntD   = '0;
        end else if (frameDone) begin
            frameCntD = frameCntQ + CNT_W'(1);
            if (frameErr && (errCntQ != ERR_SAT)) begin
                errCntD = errCntQ + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= S_DATA;
            bitCntQ   <= 2'd0;
            dataQ     <= '0;
            outDataQ  <= '0;
            outErrQ   <= 1'b0;
            frameCntQ <= '0;
            errCntQ   <= '0;
        end else begin
            stateQ    <= stateD;
            bitCntQ   <= bitCntD;
            dataQ     <= dataD;
            outDataQ  <= outDataD;
            outErrQ   <= outErrD;
            frameCntQ <= frameCntD;
            errCntQ   <= errCntD;
        end
    end

    assign out_data  = outDataQ;
    assign out_err   = outErrQ;
    assign frame_cnt = frameCntQ;
    assign err_cnt   = errCntQ;

endmodule
